// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R1-R15, PC, IR, MAR, MDR, Y, HI, LO, 64-bit Z and ALU.
// Ports:
//   Clock, Clear         : clock and synchronous active-high reset
//   *out                 : bus source selects, priority PC > ZHigh > ZLow > MDR > R2 > R4
//   *in, IncPC, Read     : register load strobes, PC increment, MDR source select
//   ADD, Cin             : ALU opcode and carry/borrow-in
//   Mdatain              : memory read data
//   BusMuxOut            : shared bus value
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             PCout,
    input  logic             ZHighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R4out,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic [4:0]       ADD,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighIn,
    input  logic             ZLowIn,
    input  logic             Cin,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    logic [WIDTH-1:0]   r_rf [1:15];
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_z;

    logic [15:1]               w_rin;
    logic [WIDTH:0]            w_sum;
    logic [WIDTH-1:0]          w_diff;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]          w_alu_lo;
    logic [WIDTH-1:0]          w_alu_hi;

    assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in};

    always_comb begin
        BusMuxOut = '0;
        if (PCout)         BusMuxOut = r_pc;
        else if (ZHighout) BusMuxOut = r_z[2*WIDTH-1:WIDTH];
        else if (Zlowout)  BusMuxOut = r_z[WIDTH-1:0];
        else if (MDRout)   BusMuxOut = r_mdr;
        else if (R2out)    BusMuxOut = r_rf[2];
        else if (R4out)    BusMuxOut = r_rf[4];
    end

    // Extra top bit of the sum is the carry-out reported in the high half.
    assign w_sum  = {1'b0, r_y} + {1'b0, BusMuxOut} + {{WIDTH{1'b0}}, Cin};
    assign w_diff = r_y - BusMuxOut - {{(WIDTH-1){1'b0}}, Cin};
    // Sign-extend both operands to full width so the low 2*WIDTH bits are the signed product.
    assign w_prod = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y})
                  * $signed({{WIDTH{BusMuxOut[WIDTH-1]}}, BusMuxOut});

    always_comb begin
        w_alu_lo = '0;
        w_alu_hi = '0;
        case (ADD)
            OP_ADD: begin
                w_alu_lo = w_sum[WIDTH-1:0];
                w_alu_hi = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            end
            OP_SUB: begin
                w_alu_lo = w_diff;
                w_alu_hi = {WIDTH{w_diff[WIDTH-1]}};
            end
            OP_AND: w_alu_lo = r_y & BusMuxOut;
            OP_OR:  w_alu_lo = r_y | BusMuxOut;
            OP_MUL: {w_alu_hi, w_alu_lo} = w_prod;
            OP_NEG: w_alu_lo = {WIDTH{1'b0}} - BusMuxOut;
            OP_NOT: w_alu_lo = ~BusMuxOut;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 1; i <= 15; i++) r_rf[i] <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_z   <= '0;
        end else begin
            for (int i = 1; i <= 15; i++)
                if (w_rin[i]) r_rf[i] <= BusMuxOut;
            if (IncPC)     r_pc  <= r_pc + 1'b1;
            else if (PCin) r_pc  <= BusMuxOut;
            if (MDRin)     r_mdr <= Read ? Mdatain : BusMuxOut;
            if (MARin)     r_mar <= BusMuxOut;
            if (IRin)      r_ir  <= BusMuxOut;
            if (Yin)       r_y   <= BusMuxOut;
            if (HIin)      r_hi  <= BusMuxOut;
            if (LOin)      r_lo  <= BusMuxOut;
            if (ZLowIn)    r_z[WIDTH-1:0]       <= w_alu_lo;
            if (ZHighIn)   r_z[2*WIDTH-1:WIDTH] <= w_alu_hi;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus random strobes
// compared against an arithmetic reference model.
module tb_datapath;

    logic        Clock;
    logic        Clear;
    logic [5:0]  osel;
    logic [15:1] rin;
    logic        marin, pcin, mdrin, irin, yin, incpc, rd;
    logic        hiin, loin, zhin, zlin, cin;
    logic [4:0]  op;
    logic [31:0] mdat;
    logic [31:0] BusMuxOut;

    int total = 0;
    int bad = 0;

    logic [31:0] m_rf [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
    logic [63:0] m_z;
    logic [31:0] exp_bus, obs_bus;

    datapath #(.WIDTH(32)) dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(osel[5]), .ZHighout(osel[4]), .Zlowout(osel[3]),
        .MDRout(osel[2]), .R2out(osel[1]), .R4out(osel[0]),
        .MARin(marin), .PCin(pcin), .MDRin(mdrin), .IRin(irin), .Yin(yin),
        .IncPC(incpc), .Read(rd), .ADD(op),
        .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]),
        .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]),
        .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]), .R12in(rin[12]),
        .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(hiin), .LOin(loin), .ZHighIn(zhin), .ZLowIn(zlin),
        .Cin(cin), .Mdatain(mdat), .BusMuxOut(BusMuxOut)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] model_bus();
        if (osel[5]) return m_pc;
        if (osel[4]) return m_z[63:32];
        if (osel[3]) return m_z[31:0];
        if (osel[2]) return m_mdr;
        if (osel[1]) return m_rf[2];
        if (osel[0]) return m_rf[4];
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(logic [31:0] a, logic [31:0] b, logic c);
        logic [63:0] s;
        logic [31:0] d;
        longint p;
        case (op)
            5'd3: begin
                s = {32'h0, a} + {32'h0, b} + {63'h0, c};
                return {31'h0, s[32], s[31:0]};
            end
            5'd4: begin
                d = a - b - {31'h0, c};
                return {{32{d[31]}}, d};
            end
            5'd5: return {32'h0, a & b};
            5'd6: return {32'h0, a | b};
            5'd15: begin
                p = longint'(signed'(a)) * longint'(signed'(b));
                return p;
            end
            5'd17: return {32'h0, 32'h0 - b};
            5'd18: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic idle();
        osel = '0; rin = '0; marin = 0; pcin = 0; mdrin = 0; irin = 0;
        yin = 0; incpc = 0; rd = 0; hiin = 0; loin = 0; zhin = 0; zlin = 0;
        cin = 0; op = 5'd0; Clear = 0;
    endtask

    // One clock: record bus vs model, then advance the model with the DUT.
    task automatic cyc();
        logic [63:0] alu;
        #1;
        exp_bus = model_bus();
        obs_bus = BusMuxOut;
        alu = model_alu(m_y, exp_bus, cin);
        @(posedge Clock);
        if (Clear) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 0;
            m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
            m_hi = 0; m_lo = 0; m_z = 0;
        end else begin
            for (int i = 1; i < 16; i++) if (rin[i]) m_rf[i] = exp_bus;
            if (incpc) m_pc = m_pc + 1;
            else if (pcin) m_pc = exp_bus;
            if (mdrin) m_mdr = rd ? mdat : exp_bus;
            if (marin) m_mar = exp_bus;
            if (irin) m_ir = exp_bus;
            if (yin) m_y = exp_bus;
            if (hiin) m_hi = exp_bus;
            if (loin) m_lo = exp_bus;
            if (zlin) m_z[31:0] = alu[31:0];
            if (zhin) m_z[63:32] = alu[63:32];
        end
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        mdat = v; rd = 1; mdrin = 1;
        cyc();
    endtask

    task automatic test_reset();
        idle(); Clear = 1; cyc();
        for (int k = 0; k < 6; k++) begin
            osel = 6'b000100; rin = 15'($urandom); mdat = $urandom; rd = 1;
            mdrin = 1; yin = 1; pcin = 1; marin = 1; irin = 1; hiin = 1; loin = 1;
            zhin = 1; zlin = 1; op = 5'd3;
            cyc();
        end
        Clear = 1; mdrin = 1; rd = 1; mdat = 32'hDEAD_BEEF; incpc = 1; rin = '1;
        cyc();
        for (int i = 1; i < 16; i++) begin
            total++;
            if (dut.r_rf[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset_R%0d: got %h want 0", i, dut.r_rf[i]);
            end
        end
        total++;
        if ({dut.r_pc, dut.r_ir, dut.r_mar, dut.r_mdr, dut.r_y, dut.r_hi, dut.r_lo} !== 224'h0
            || dut.r_z !== 64'h0) begin
            bad++;
            $display("FAIL reset_regs: pc=%h ir=%h mar=%h mdr=%h y=%h z=%h",
                     dut.r_pc, dut.r_ir, dut.r_mar, dut.r_mdr, dut.r_y, dut.r_z);
        end
        for (int b = 0; b < 6; b++) begin
            osel = 6'(1 << b);
            #1;
            total++;
            if (BusMuxOut !== 32'h0) begin
                bad++;
                $display("FAIL reset_bus%0d: got %h want 0", b, BusMuxOut);
            end
        end
        idle();
    endtask

    task automatic test_reg_load();
        logic [31:0] vals [3];
        int dst [3];
        vals = '{32'h22, 32'h24, 32'h27};
        dst = '{2, 4, 5};
        for (int k = 0; k < 3; k++) begin
            load_mdr(vals[k]);
            osel = 6'b000100; rin[dst[k]] = 1;
            cyc();
            total++;
            if (obs_bus !== vals[k]) begin
                bad++;
                $display("FAIL load_bus%0d: got %h want %h", k, obs_bus, vals[k]);
            end
            total++;
            if (dut.r_rf[dst[k]] !== vals[k]) begin
                bad++;
                $display("FAIL load_R%0d: got %h want %h", dst[k], dut.r_rf[dst[k]], vals[k]);
            end
        end
    endtask

    task automatic test_add_seq();
        osel = 6'b000010; yin = 1; cyc();
        total++;
        if (dut.r_y !== 32'h22) begin
            bad++;
            $display("FAIL add_y: got %h want 00000022", dut.r_y);
        end
        osel = 6'b000001; op = 5'b00011; cin = 0; zlin = 1; cyc();
        total++;
        if (dut.r_z[31:0] !== 32'h46) begin
            bad++;
            $display("FAIL add_zlo: got %h want 00000046", dut.r_z[31:0]);
        end
        osel = 6'b001000; rin[5] = 1; cyc();
        total++;
        if (dut.r_rf[5] !== 32'h46) begin
            bad++;
            $display("FAIL add_R5: got %h want 00000046", dut.r_rf[5]);
        end
    endtask

    task automatic test_pc_fetch();
        load_mdr(32'h7);
        osel = 6'b000100; pcin = 1; cyc();
        osel = 6'b100000; marin = 1; incpc = 1; pcin = 1; cyc();
        total++;
        if (obs_bus !== 32'h7 || dut.r_mar !== 32'h7 || dut.r_pc !== 32'h8) begin
            bad++;
            $display("FAIL pc_fetch: bus=%h mar=%h pc=%h want 7/7/8",
                     obs_bus, dut.r_mar, dut.r_pc);
        end
        load_mdr(32'h4A92_0000);
        osel = 6'b000100; irin = 1; cyc();
        total++;
        if (dut.r_ir !== 32'h4A92_0000) begin
            bad++;
            $display("FAIL pc_ir: got %h want 4a920000", dut.r_ir);
        end
        load_mdr(32'hFFFF_FFFF);
        osel = 6'b000100; pcin = 1; cyc();
        incpc = 1; cyc();
        total++;
        if (dut.r_pc !== 32'h0) begin
            bad++;
            $display("FAIL pc_wrap: got %h want 0", dut.r_pc);
        end
    endtask

    task automatic test_carry_mul();
        load_mdr(32'hFFFF_FFFF);
        osel = 6'b000100; yin = 1; cyc();
        load_mdr(32'h1);
        osel = 6'b000100; op = 5'b00011; zlin = 1; zhin = 1; cyc();
        total++;
        if (dut.r_z !== 64'h1_0000_0000) begin
            bad++;
            $display("FAIL carry_z: got %h want 0000000100000000", dut.r_z);
        end
        load_mdr(32'hFFFF_FFFE);
        osel = 6'b000100; yin = 1; cyc();
        load_mdr(32'h3);
        osel = 6'b000100; op = 5'b01111; zlin = 1; zhin = 1; cyc();
        total++;
        if (dut.r_z !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            bad++;
            $display("FAIL mul_z: got %h want fffffffffffffffa", dut.r_z);
        end
        osel = 6'b010000; rin[7] = 1; cyc();
        total++;
        if (dut.r_rf[7] !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL zhigh_R7: got %h want ffffffff", dut.r_rf[7]);
        end
    endtask

    task automatic test_bus_priority();
        load_mdr(32'h1234_5678);
        #1;
        total++;
        if (BusMuxOut !== 32'h0) begin
            bad++;
            $display("FAIL bus_idle: got %h want 0", BusMuxOut);
        end
        osel = 6'b100100;
        #1;
        total++;
        if (BusMuxOut !== m_pc) begin
            bad++;
            $display("FAIL bus_prio: got %h want %h", BusMuxOut, m_pc);
        end
        idle();
    endtask

    task automatic test_random();
        logic [4:0] ops [9];
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd17, 5'd18, 5'd0, 5'd31};
        for (int n = 0; n < 400; n++) begin
            osel = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            rin = 15'($urandom & $urandom);
            {marin, pcin, mdrin, irin, yin, incpc} = 6'($urandom);
            {rd, hiin, loin, zhin, zlin, cin} = 6'($urandom);
            op = ops[$urandom_range(0, 8)];
            mdat = $urandom;
            Clear = ($urandom_range(0, 40) == 0);
            cyc();
            total++;
            if (obs_bus !== exp_bus) begin
                bad++;
                $display("FAIL rnd_bus n=%0d: got %h want %h", n, obs_bus, exp_bus);
            end
            for (int i = 1; i < 16; i++) begin
                total++;
                if (dut.r_rf[i] !== m_rf[i]) begin
                    bad++;
                    $display("FAIL rnd_R%0d n=%0d: got %h want %h", i, n, dut.r_rf[i], m_rf[i]);
                end
            end
            total++;
            if ({dut.r_pc, dut.r_ir, dut.r_mar, dut.r_mdr, dut.r_y, dut.r_hi, dut.r_lo, dut.r_z}
                !== {m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_z}) begin
                bad++;
                $display("FAIL rnd_regs n=%0d: pc=%h/%h mdr=%h/%h y=%h/%h z=%h/%h", n,
                         dut.r_pc, m_pc, dut.r_mdr, m_mdr, dut.r_y, m_y, dut.r_z, m_z);
            end
        end
    endtask

    initial begin
        idle();
        mdat = 0;
        for (int i = 0; i < 16; i++) m_rf[i] = 0;
        @(negedge Clock);
        test_reset();
        test_reg_load();
        test_add_seq();
        test_pc_fetch();
        test_carry_mul();
        test_bus_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath: register file R1–R15, PC, IR, MAR, MDR, Y, HI, LO, a 64-bit Z result register and a combinational ALU, all joined by one shared 32-bit bus.
- The external control unit or bench drives one-hot style "out" (bus source) and "in" (register load) strobes plus an ALU opcode.
- The internal bus is exported as BusMuxOut for observation.

Parameters:
- WIDTH, 32, data and bus width (all registers WIDTH bits; Z is 2*WIDTH).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  reset. One clock; reset is synchronous and active-high.
- PCout, ZHighout, Zlowout, MDRout, R2out, R4out  in  1 each  bus-source selects (PC, Z[63:32], Z[31:0], MDR, R2, R4).
- MARin, PCin, MDRin, IRin, Yin  in  1 each  load strobes for MAR, PC, MDR, IR, Y.
- IncPC  in  1  increment PC.
- Read  in  1  MDR input select (1 = Mdatain, 0 = bus).
- ADD  in  5  ALU opcode.
- R1in..R15in  in  1 each  register-file load strobes.
- HIin, LOin  in  1 each  load HI/LO from bus.
- ZHighIn, ZLowIn  in  1 each  load Z[63:32] / Z[31:0] from ALU result.
- Cin  in  1  ALU carry-in for ADD/SUB.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value (combinational).

Behaviour:
- Reset: when Clear=1 at a rising edge, every register (R1–R15, PC, IR, MAR, MDR, Y, HI, LO, Z) becomes 0. Clear has priority over all loads.
- Bus mux is combinational. Priority order: PCout > ZHighout > Zlowout > MDRout > R2out > R4out. If no out-strobe is asserted, the bus is 0. Multiple out-strobes are a control error but resolve by this priority.
- Register loads occur at the rising edge while the strobe is high, capturing BusMuxOut. Several in-strobes may be active in the same cycle; all of them load.
- MDR input: Read=1 gives Mdatain, Read=0 gives BusMuxOut. MDR loads only when MDRin=1.
- PC: IncPC=1 gives PC <= PC+1 (wraps at 2^32). Otherwise PCin=1 gives PC <= bus. IncPC has priority over PCin. The bus sees the pre-increment PC in the same cycle.
- ALU operands: A=Y, B=BusMuxOut. The result is a 64-bit combinational value {hi, lo}.
- Opcodes:
  - 00011 ADD: lo = A+B+Cin, hi = {31'b0, carry-out}.
  - 00100 SUB: lo = A-B-Cin, hi = sign-extension of lo[31].
  - 00101 AND: lo = A&B, hi = 0.
  - 00110 OR: lo = A|B, hi = 0.
  - 01111 MUL: {hi, lo} = signed A*B, full 64-bit product.
  - 10001 NEG: lo = -B, hi = 0.
  - 10010 NOT: lo = ~B, hi = 0.
  - All other opcodes: {hi, lo} = 0.
- Z: ZLowIn loads Z[31:0] <= lo; ZHighIn loads Z[63:32] <= hi; each half loads independently.
- Latency: a register loaded at edge k is visible on the bus from edge k onward, so a reg-to-reg move takes 1 cycle. The ALU path is Y load (1 cycle), then Z load (1 cycle), then move Z to destination (1 cycle).
- IR, MAR, HI and LO have no bus outputs in this block. Their values are internal but must be inspectable in simulation.

Test Plan:
- Reset: hold Clear=1 for one edge after arbitrary loads → BusMuxOut=0 with each out-strobe; all registers read 0.
- Register load: Mdatain=0x22, Read=MDRin=1 for one edge; then MDRout=R2in=1 → BusMuxOut=0x22, R2=0x22. Repeat with 0x24 into R4 and 0x27 into R5.
- ADD sequence: R2out+Yin (Y=0x22); then R4out, ADD=00011, Cin=0, ZLowIn (Z lo=0x46); then Zlowout+R5in → R5=0x46, overwriting 0x27.
- PC fetch: MDR=0x07, MDRout+PCin → PC=7; then PCout+MARin+IncPC → MAR=7, PC=8. Then Mdatain=0x4A920000 with Read+MDRin, then MDRout+IRin → IR=0x4A920000.
- Carry/high half: Y=0xFFFFFFFF, B=1, ADD, ZLowIn+ZHighIn → Z lo=0, Z hi=1. MUL of Y=-2 and B=3 → Z={0xFFFFFFFF, 0xFFFFFFFA}.
- Bus priority/idle: no out-strobes → BusMuxOut=0. PCout and MDRout both high → bus shows PC.
